// File: rtl/zx81_video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zx81_video_pkg
// Description : Shared types and default timing constants for the ZX81-style
//               video sync generator.
// Revision    : 1.0 - initial release
// ============================================================================
package zx81_video_pkg;

    // Width of the line counter (0..311 needs 9 bits)
    localparam int LINE_W = 9;

    // Default frame timing, in counter steps and lines
    localparam int c_def_hsync_start  = 192;
    localparam int c_def_hsync_len    = 15;
    localparam int c_def_lines        = 312;
    localparam int c_def_vsync_lines  = 4;
    localparam int c_def_top_lines    = 56;
    localparam int c_def_active_lines = 192;

    // Vertical phase of the frame
    typedef enum logic [1:0] {
        VSYNC  = 2'd0,
        TOP    = 2'd1,
        ACTIVE = 2'd2,
        BOTTOM = 2'd3
    } state_t;

endpackage : zx81_video_pkg
`default_nettype wire

// File: rtl/zx81_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : zx81_sync_gen
// Description : Derives horizontal sync, line count, vertical sync/blanking
//               and per-line NMI from a free-running upstream T-state counter.
//               A line boundary is any backwards step of the counter value.
// Revision    : 1.0 - initial release
// ============================================================================
module zx81_sync_gen
    import zx81_video_pkg::*;
#(
    parameter int HSYNC_START  = c_def_hsync_start,
    parameter int HSYNC_LEN    = c_def_hsync_len,
    parameter int LINES        = c_def_lines,
    parameter int VSYNC_LINES  = c_def_vsync_lines,
    parameter int TOP_LINES    = c_def_top_lines,
    parameter int ACTIVE_LINES = c_def_active_lines
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        count,
    output logic              hsync,
    output logic              vsync,
    output logic              active,
    output logic [LINE_W-1:0] line,
    output logic              nmi,
    output logic              frame_tick
);

    // Line boundaries of each vertical phase
    localparam logic [LINE_W-1:0] c_last_line = LINE_W'(LINES - 1);
    localparam logic [LINE_W-1:0] c_top_first = LINE_W'(VSYNC_LINES);
    localparam logic [LINE_W-1:0] c_act_first = LINE_W'(VSYNC_LINES + TOP_LINES);
    localparam logic [LINE_W-1:0] c_bot_first = LINE_W'(VSYNC_LINES + TOP_LINES + ACTIVE_LINES);

    // Hsync window; the end is formed 9 bits wide so it saturates at 255
    // instead of wrapping round to the start of the line.
    localparam logic [7:0] c_hs_start = 8'(HSYNC_START);
    localparam logic [8:0] c_hs_end9  = 9'(HSYNC_START) + 9'(HSYNC_LEN) - 9'd1;
    localparam logic [7:0] c_hs_end   = c_hs_end9[8] ? 8'd255 : c_hs_end9[7:0];

    logic [7:0]        r_count_q;
    state_t            r_state;
    state_t            w_state_next;
    logic              w_wrap;
    logic              w_last;
    logic [LINE_W-1:0] w_line_next;
    logic              w_hsync_next;

    // Wrap detection and next line number
    assign w_wrap      = (count < r_count_q);
    assign w_last      = (line == c_last_line);
    assign w_line_next = !w_wrap ? line : (w_last ? '0 : line + 1'b1);

    // Hsync window decode on the current counter value
    assign w_hsync_next = (count >= c_hs_start) && (count <= c_hs_end);

    // Vertical phase decoded from the line number about to be registered
    always_comb begin
        w_state_next = r_state;
        if (w_wrap) begin
            if (w_line_next < c_top_first)
                w_state_next = VSYNC;
            else if (w_line_next < c_act_first)
                w_state_next = TOP;
            else if (w_line_next < c_bot_first)
                w_state_next = ACTIVE;
            else
                w_state_next = BOTTOM;
        end
    end

    // State register, line counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count_q  <= '0;
            r_state    <= VSYNC;
            line       <= '0;
            hsync      <= 1'b0;
            vsync      <= 1'b1;
            active     <= 1'b0;
            nmi        <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            r_count_q  <= count;
            r_state    <= w_state_next;
            line       <= w_line_next;
            hsync      <= w_hsync_next;
            vsync      <= (w_state_next == VSYNC);
            active     <= (w_state_next == ACTIVE);
            nmi        <= w_wrap && (w_state_next != ACTIVE);
            frame_tick <= w_wrap && w_last;
        end
    end

endmodule : zx81_sync_gen
`default_nettype wire

// File: tb/tb_zx81_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_zx81_sync_gen
// Description : Directed, table-driven self-checking bench for zx81_sync_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zx81_sync_gen;

    logic       clk;
    logic       reset;
    logic [7:0] count;
    logic       hsync;
    logic       vsync;
    logic       active;
    logic [8:0] line;
    logic       nmi;
    logic       frame_tick;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [7:0] cnt;
        logic       hs;
        logic [8:0] ln;
        logic       nm;
        logic       ft;
        logic       vs;
        logic       ac;
    } vec_t;

    vec_t vecs [15];

    zx81_sync_gen dut (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .hsync      (hsync),
        .vsync      (vsync),
        .active     (active),
        .line       (line),
        .nmi        (nmi),
        .frame_tick (frame_tick)
    );

    // 100 MHz-style free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic hs, input logic [8:0] ln,
                           input logic nm, input logic ft, input logic vs, input logic ac);
        chk({tag, ".hsync"},      {8'd0, hsync},      {8'd0, hs});
        chk({tag, ".line"},       line,               ln);
        chk({tag, ".nmi"},        {8'd0, nmi},        {8'd0, nm});
        chk({tag, ".frame_tick"}, {8'd0, frame_tick}, {8'd0, ft});
        chk({tag, ".vsync"},      {8'd0, vsync},      {8'd0, vs});
        chk({tag, ".active"},     {8'd0, active},     {8'd0, ac});
    endtask

    // Apply a count, clock once, and settle just after the edge
    task automatic tick(input logic [7:0] c);
        count = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        count = 8'd0;
        repeat (3) tick(8'd0);
        #2 reset = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        count = 8'd0;

        //                 cnt     hs  line  nmi ft  vs  ac
        vecs[0]  = '{8'd0,   1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{8'd191, 1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{8'd192, 1'b1, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{8'd206, 1'b1, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{8'd207, 1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{8'd255, 1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{8'd0,   1'b0, 9'd1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{8'd0,   1'b0, 9'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{8'd100, 1'b0, 9'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{8'd50,  1'b0, 9'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{8'd50,  1'b0, 9'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{8'd192, 1'b1, 9'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{8'd10,  1'b0, 9'd3, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{8'd5,   1'b0, 9'd4, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{8'd200, 1'b1, 9'd4, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset held while count toggles
        repeat (4) begin
            tick(8'd255);
            tick(8'd0);
        end
        count = 8'd193;
        #3;
        chk_all("reset_hold", 1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Table-driven vectors from a clean reset
        do_reset();
        for (int i = 0; i < 15; i++) begin
            tick(vecs[i].cnt);
            chk_all($sformatf("vec%0d", i), vecs[i].hs, vecs[i].ln, vecs[i].nm,
                    vecs[i].ft, vecs[i].vs, vecs[i].ac);
        end

        // Full sweep: hsync width and unchanged line
        begin
            int hs_cycles;
            do_reset();
            hs_cycles = 0;
            for (int c = 0; c < 256; c++) begin
                tick(8'(c));
                if (hsync) hs_cycles++;
                chk("sweep.hsync", {8'd0, hsync}, {8'd0, 1'(c >= 192 && c <= 206)});
            end
            chk("sweep.hs_width", 9'(hs_cycles), 9'd15);
            chk("sweep.line", line, 9'd0);
        end

        // One whole frame of 255 -> 0 wraps
        do_reset();
        for (int k = 1; k <= 312; k++) begin
            int ln;
            tick(8'd255);
            chk("frame.nmi_idle", {8'd0, nmi}, 9'd0);
            chk("frame.ft_idle",  {8'd0, frame_tick}, 9'd0);
            tick(8'd0);
            ln = k % 312;
            chk($sformatf("frame%0d.line", k), line, 9'(ln));
            chk($sformatf("frame%0d.vsync", k), {8'd0, vsync}, {8'd0, 1'(ln < 4)});
            chk($sformatf("frame%0d.active", k), {8'd0, active},
                {8'd0, 1'(ln >= 60 && ln <= 251)});
            chk($sformatf("frame%0d.nmi", k), {8'd0, nmi},
                {8'd0, 1'(!(ln >= 60 && ln <= 251))});
            chk($sformatf("frame%0d.ft", k), {8'd0, frame_tick}, {8'd0, 1'(k == 312)});
        end
        tick(8'd100);
        chk("frame.ft_one_cycle", {8'd0, frame_tick}, 9'd0);
        chk("frame.nmi_one_cycle", {8'd0, nmi}, 9'd0);

        // Stalled counter then a single backwards step
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(8'd50);
            chk("stall.line", line, 9'd0);
            chk("stall.nmi", {8'd0, nmi}, 9'd0);
        end
        tick(8'd20);
        chk("stall_wrap.line", line, 9'd1);
        chk("stall_wrap.nmi", {8'd0, nmi}, 9'd1);
        tick(8'd20);
        chk("stall_after.line", line, 9'd1);

        // Asynchronous reset mid-frame at line 100
        do_reset();
        for (int k = 0; k < 100; k++) begin
            tick(8'd255);
            tick(8'd0);
        end
        chk("mid.pre_line", line, 9'd100);
        chk("mid.pre_active", {8'd0, active}, 9'd1);
        tick(8'd195);
        chk("mid.pre_hsync", {8'd0, hsync}, 9'd1);
        #2 reset = 1'b0;
        #1;
        chk_all("mid_async", 1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(8'd195);
        tick(8'd0);
        #2 reset = 1'b1;
        tick(8'd0);
        chk_all("post_release", 1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(8'd255);
        tick(8'd0);
        chk_all("post_release_wrap", 1'b0, 9'd1, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_zx81_sync_gen
`default_nettype wire
